demux_1_8_deser: RTL and testbench
==================================

Name: demux_1_8_deser

Overview:
- Receive-side counterpart of the team's 8:1 mux.
- Takes a TDM serial bit stream and demultiplexes it into eight registered 1-bit outputs a..h.
- Slot 0 maps to a, slot 7 maps to h, matching mux sel encoding (sel=0 selects a).
- Adds frame alignment (sof), an idle timeout, and a valid/ready output handshake so a slow consumer can back-pressure the serial source.

Parameters:
TIMEOUT, 15, idle cycles allowed inside a partial frame before it is discarded; 0 disables timeout; counter width $clog2(TIMEOUT+1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
din  input  1  serial data bit
in_valid  input  1  din/sof qualified
in_ready  output  1  block accepts din this cycle (combinational)
sof  input  1  start of frame; din is slot-0 bit
a,b,c,d,e,f,g,h  output  1 each  registered frame bits, slots 0..7
out_valid  output  1  a..h hold a complete frame
out_ready  input  1  consumer takes frame
sel  output  3  next slot to be written (registered)
err  output  1  one-cycle pulse on framing/timeout error

Behaviour:
- Reset (rst_n low, async): state IDLE, sel=0, a..h=0, out_valid=0, err=0, assembly reg asm[7:0]=0, idle counter 0. in_ready=1 while in reset release.
- Accept = in_valid && in_ready.
- in_ready = 0 only when state==COLLECT && sel==7 && out_valid && !out_ready; otherwise 1.
- States: IDLE (waiting for sof), COLLECT (slots 1..7 pending).
- IDLE:
  - Accept with sof=1: asm[0]=din, sel=1, go COLLECT.
  - Accept with sof=0: bit dropped, err=1 for one cycle, sel stays 0.
- COLLECT, accept with sof=0, sel<7: asm[sel]=din, sel+1.
- COLLECT, accept with sof=0, sel==7 (frame complete):
  - {a..h} <= {asm[0..6], din}, out_valid<=1, sel=0, go IDLE.
  - Latency: frame visible the cycle after the slot-7 accept.
- COLLECT, accept with sof=1 (resync):
  - err pulse; partial frame discarded (asm cleared).
  - asm[0]=din, sel=1, stay COLLECT.
- Timeout (TIMEOUT>0):
  - Idle counter increments in COLLECT on cycles with in_valid=0.
  - Cleared on accept and on entry to COLLECT.
  - Stalled cycles (in_valid=1, in_ready=0) neither count nor clear.
  - Counter reaching TIMEOUT: err pulse, asm cleared, sel=0, go IDLE, counter 0.
  - An accept in the same cycle takes priority over timeout.
- Output handshake:
  - out_valid && out_ready consumes the frame; out_valid clears next cycle unless a new frame completes that same cycle, in which case out_valid stays 1 and a..h load the new frame.
  - a..h change only on frame completion; held otherwise, including across errors.
- sel wraps 7->0 only via completion; no other wrap path.
- err is never asserted for two causes at once beyond a single one-cycle pulse.

Test Plan:
- Reset mid-frame: 4 bits accepted, rst_n low -> sel=0, out_valid=0, a..h=0 without waiting for clk; next sof frame decodes normally.
- Basic frame, out_ready=1: bits 1,0,1,1,0,0,1,0 with sof on first -> cycle after 8th accept out_valid=1 for one cycle, a=1 b=0 c=1 d=1 e=0 f=0 g=1 h=0, err=0.
- Back-pressure, out_ready=0: frames 0xFF then 0x00 back to back -> a..h=1 held; in_ready=0 at slot 7 of second frame. Raise out_ready -> slot 7 accepted, next cycle a..h=0, out_valid stays 1.
- Resync: sof asserted at sel=4 -> err pulse, sel=1; following 7 bits complete a frame containing the resync bit in a.
- Timeout, TIMEOUT=4: 3 bits accepted then in_valid=0 for 4 cycles -> err pulse, sel=0, IDLE; a following non-sof bit is dropped with a second err pulse.
- Stall not counted: TIMEOUT=4, out_ready=0 holding in_ready low with in_valid=1 for 10 cycles at slot 7 -> no err, frame completes after release.

Source files
------------

// File: rtl/demux_1_8_deser.sv
// 1:8 TDM deserializer: assembles sof-aligned 8-bit frames from a serial stream and
// presents them on registered outputs a..h with a valid/ready handshake and idle timeout.
module demux_1_8_deser #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       sof,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic       err
);

    // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t           state, state_next;
    logic [2:0]       sel_next;
    logic [7:0]       asm_q, asm_next;
    logic [7:0]       frame, frame_next;
    logic             out_valid_next;
    logic             err_next;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_next;
    logic             accept;

    // Only the slot-7 bit can be refused: it would overwrite a frame not yet taken.
    assign in_ready = !(state == COLLECT && sel == 3'd7 && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    assign {h, g, f, e, d, c, b, a} = frame;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_next     = state;
        sel_next       = sel;
        asm_next       = asm_q;
        frame_next     = frame;
        out_valid_next = out_valid && !out_ready;
        err_next       = 1'b0;
        idle_cnt_next  = idle_cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (sof) begin
                        asm_next      = {7'd0, din};
                        sel_next      = 3'd1;
                        idle_cnt_next = '0;
                        state_next    = COLLECT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    idle_cnt_next = '0;
                    if (sof) begin
                        err_next = 1'b1;
                        asm_next = {7'd0, din};
                        sel_next = 3'd1;
                    end else if (sel == 3'd7) begin
                        frame_next     = {din, asm_q[6:0]};
                        out_valid_next = 1'b1;
                        sel_next       = 3'd0;
                        state_next     = IDLE;
                    end else begin
                        asm_next[sel] = din;
                        sel_next      = sel + 3'd1;
                    end
                end else if (TIMEOUT > 0 && !in_valid) begin
                    if (idle_cnt == CNT_LAST) begin
                        err_next      = 1'b1;
                        asm_next      = '0;
                        sel_next      = 3'd0;
                        idle_cnt_next = '0;
                        state_next    = IDLE;
                    end else begin
                        idle_cnt_next = idle_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 3'd0;
            asm_q     <= '0;
            frame     <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_next;
            sel       <= sel_next;
            asm_q     <= asm_next;
            frame     <= frame_next;
            out_valid <= out_valid_next;
            err       <= err_next;
            idle_cnt  <= idle_cnt_next;
        end
    end

endmodule

// File: tb/tb_demux_1_8_deser.sv
// Scoreboard bench for demux_1_8_deser: stimulus pushes expected frames {h..a},
// a monitor pops and compares on every out_valid && out_ready handshake.
module tb_demux_1_8_deser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din, in_valid, sof, out_ready;
    logic       in_ready, out_valid, err;
    logic       a, b, c, d, e, f, g, h;
    logic [2:0] sel;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    logic [7:0] exp_q[$];

    demux_1_8_deser #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .sof(sof), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid), .out_ready(out_ready), .sel(sel), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {h, g, f, e, d, c, b, a};
    endfunction

    // Monitor: counts err pulses and scores every consumed frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (err === 1'b1) err_seen++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {24'd0, outs()}, 32'hdead);
                end else begin
                    check("frame", {24'd0, outs()}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Present one bit until accepted (bounded), returning at posedge+1 of the accept edge.
    task automatic send(input logic bit_val, input logic sof_val);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        din = bit_val; sof = sof_val; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0; din = 1'b0; sof = 1'b0;
    endtask

    // Bit i of slots is sent in slot i; sof on slot 0.
    task automatic send_bits(input logic [7:0] slots, input int count);
        for (int i = 0; i < count; i++) send(slots[i], i == 0);
    endtask

    initial begin
        int err_base;
        rst_n = 1'b0; din = 1'b0; in_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_sel", {29'd0, sel}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outs", {24'd0, outs()}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of a frame, asserted away from any clock edge.
        send_bits(8'hFF, 4);
        check("mid_sel", {29'd0, sel}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sel", {29'd0, sel}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_outs", {24'd0, outs()}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame 1,0,1,1,0,0,1,0 -> a=1 b=0 c=1 d=1 e=0 f=0 g=1 h=0.
        err_base = err_seen;
        exp_q.push_back(8'h4D);
        send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
        send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
        check("basic_out_valid", {31'd0, out_valid}, 32'd1);
        check("basic_outs", {24'd0, outs()}, 32'h4D);
        check("basic_sel", {29'd0, sel}, 32'd0);
        check("basic_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        check("basic_valid_drop", {31'd0, out_valid}, 32'd0);
        check("basic_no_err", err_seen - err_base, 32'd0);

        // Back-pressure: 0xFF held while 0x00 stalls at slot 7 for 10 cycles.
        out_ready = 1'b0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send_bits(8'hFF, 8);
        send_bits(8'h00, 7);
        check("bp_outs_held", {24'd0, outs()}, 32'hFF);
        check("bp_sel7", {29'd0, sel}, 32'd7);
        in_valid = 1'b1; din = 1'b0; sof = 1'b0;
        #1;
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("stall_sel", {29'd0, sel}, 32'd7);
        check("stall_outs", {24'd0, outs()}, 32'hFF);
        check("stall_no_err", err_seen - err_base, 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_new_valid", {31'd0, out_valid}, 32'd1);
        check("bp_new_outs", {24'd0, outs()}, 32'h00);
        @(posedge clk); #1;
        check("bp_valid_drop", {31'd0, out_valid}, 32'd0);

        // Resync at sel=4; bits after resync 1,0,1,0,0,1,1,0 -> 0x65.
        send_bits(8'h0F, 4);
        check("rs_sel4", {29'd0, sel}, 32'd4);
        err_base = err_seen;
        send(1'b1, 1'b1);
        check("rs_err", {31'd0, err}, 32'd1);
        check("rs_sel1", {29'd0, sel}, 32'd1);
        exp_q.push_back(8'h65);
        send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
        send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b0, 1'b0);
        check("rs_outs", {24'd0, outs()}, 32'h65);
        check("rs_err_count", err_seen - err_base, 32'd1);

        // Timeout after 3 bits and 4 idle cycles, then a dropped non-sof bit.
        err_base = err_seen;
        send_bits(8'h07, 3);
        repeat (3) @(posedge clk);
        #1;
        check("to_no_err_yet", {31'd0, err}, 32'd0);
        check("to_sel3", {29'd0, sel}, 32'd3);
        @(posedge clk); #1;
        check("to_err", {31'd0, err}, 32'd1);
        check("to_sel0", {29'd0, sel}, 32'd0);
        send(1'b1, 1'b0);
        check("drop_err", {31'd0, err}, 32'd1);
        check("drop_sel0", {29'd0, sel}, 32'd0);
        @(posedge clk); #1;
        check("to_err_count", err_seen - err_base, 32'd2);
        check("to_outs_held", {24'd0, outs()}, 32'h65);
        check("to_out_valid", {31'd0, out_valid}, 32'd0);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
